qaddsub_pipe: RTL

//  Pipelined, parametrised sign-magnitude fixed-point add/subtract unit; successor to the combinational Q-format adder.
//  Per-transaction op select (add/sub), valid/ready handshake on both sides, overflow detect with optional saturation,

---
 rtl/qaddsub_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/qaddsub_pipe.sv
// qaddsub_pipe: two-stage pipelined sign-magnitude add/subtract with
// valid/ready handshake on both sides, overflow detect (optional
// saturation) and a sticky overflow flag.
module qaddsub_pipe #(
    parameter int N   = 32,
    parameter int Q   = 15,
    parameter int SAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf,
    output logic         ovf_sticky,
    input  logic         clr_sticky
);

    // Format sanity: need a sign bit plus at least two magnitude bits,
    // and the fraction must fit inside the magnitude.
    if (N < 3 || Q < 0 || Q >= N - 1) begin : g_bad_params
        $error("qaddsub_pipe: invalid N/Q combination");
    end

    // Stage 1 registers: decoded signs, magnitudes and magnitude compare
    logic           s1_valid;
    logic           s1_sa;
    logic           s1_sb;
    logic [N-2:0]   s1_ma;
    logic [N-2:0]   s1_mb;
    logic           s1_gte;

    logic           adv1;
    logic           adv2;

    // Stage 2 combinational result
    logic [N-1:0]   sum;
    logic [N-2:0]   diff_ab;
    logic [N-2:0]   diff_ba;
    logic [N-2:0]   res_mag;
    logic           res_sign;
    logic           res_ovf;

    // Ready chain: a stage advances when the stage after it can take its content
    always_comb begin
        adv2     = ~out_valid | out_ready;
        adv1     = ~s1_valid | adv2;
        in_ready = adv1;
    end

    // Stage 1: capture operands, fold op into B's sign, precompute ma >= mb
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_gte   <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sa  <= a[N-1];
                s1_sb  <= b[N-1] ^ op;
                s1_ma  <= a[N-2:0];
                s1_mb  <= b[N-2:0];
                s1_gte <= (a[N-2:0] >= b[N-2:0]);
            end
        end
    end

    // Stage 2 arithmetic: like signs add magnitudes, unlike signs subtract smaller from larger
    always_comb begin
        sum      = {1'b0, s1_ma} + {1'b0, s1_mb};
        diff_ab  = s1_ma - s1_mb;
        diff_ba  = s1_mb - s1_ma;
        res_ovf  = 1'b0;
        res_sign = s1_sa;
        res_mag  = '0;
        if (s1_sa == s1_sb) begin
            res_ovf = sum[N-1];
            res_mag = sum[N-2:0];
            if (sum[N-1] && SAT != 0) begin
                res_mag = '1;
            end
        end else if (s1_gte) begin
            res_mag = diff_ab;
        end else begin
            res_mag  = diff_ba;
            res_sign = s1_sb;
        end
        // Never produce negative zero, including a wrapped overflow to zero
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

    // Stage 2 output registers: drive c/ovf/out_valid directly, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                c   <= {res_sign, res_mag};
                ovf <= res_ovf;
            end
        end
    end

    // Sticky overflow: set on delivery of an overflowed result; set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule
